// File: rtl/fm_ch_seq.sv
// fm_ch_seq: round-robin channel sequencer for the FM synthesiser.
// Latches per-channel attributes once per slot and flags key-on/key-off transitions.
module fm_ch_seq #(
  parameter int NUM_CH     = 18,
  parameter int CYC_PER_CH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [4:0] ch_sel,
  input  logic       ch_kon,
  input  logic [2:0] ch_block,
  input  logic [9:0] ch_fnum,
  output logic       slot_start,
  output logic [4:0] op_ch,
  output logic [2:0] op_block,
  output logic [9:0] op_fnum,
  output logic       op_kon,
  output logic       kon_evt,
  output logic       koff_evt,
  output logic       frame_end
);
  localparam int CW = $clog2(CYC_PER_CH);
  logic [CW-1:0]     r_cyc;
  logic [NUM_CH-1:0] r_kon_prev;
  logic              w_sample, w_slot_end, w_last, w_prev;
  assign w_sample   = enable && (r_cyc == '0);
  assign w_slot_end = r_cyc == CW'(CYC_PER_CH - 1);
  assign w_last     = ch_sel == 5'(NUM_CH - 1);
  assign w_prev     = r_kon_prev[ch_sel];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc      <= '0;
      ch_sel     <= '0;
      r_kon_prev <= '0;
      op_ch      <= '0;
      op_block   <= '0;
      op_fnum    <= '0;
      op_kon     <= 1'b0;
      slot_start <= 1'b0;
      kon_evt    <= 1'b0;
      koff_evt   <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      slot_start <= w_sample;
      kon_evt    <= w_sample & ch_kon & ~w_prev;
      koff_evt   <= w_sample & ~ch_kon & w_prev;
      frame_end  <= enable & w_slot_end & w_last;
      if (enable) begin
        r_cyc <= w_slot_end ? '0 : r_cyc + 1'b1;
        if (w_slot_end) ch_sel <= w_last ? '0 : ch_sel + 1'b1;
      end
      // ch_sel is registered and the RAM read is combinational, so inputs are stable here
      if (w_sample) begin
        op_ch               <= ch_sel;
        op_block            <= ch_block;
        op_fnum             <= ch_fnum;
        op_kon              <= ch_kon;
        r_kon_prev[ch_sel]  <= ch_kon;
      end
    end
  end
endmodule
